multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Multi-cycle control unit directly downstream of the instruction fetch unit.
- Latches the fetched word into an internal instruction register and steps a Moore FSM through the instruction's phases.
- Drives the fetch unit's PC controls (pc_wr, npc_sel, jsome, jr) and the datapath's register-file, ALU and memory strobes.
- Supported instructions: addu, subu, ori, lui, lw, sw, beq, j, jal, jr.

Parameters:
- CNT_W, 32: width of the performance counters; only used when the optional feature is compiled in.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- code  input  32  instruction word from the fetch unit; valid in FETCH.
- zero  input  1  ALU equality flag.
- ir  output  32  latched instruction. Feeds the datapath and the fetch unit's branch/jump field inputs.
- pc_wr  output  1  PC write enable to the fetch unit.
- npc_sel  output  1  branch target select.
- jsome  output  1  j/jal target select.
- jr  output  1  register target select.
- reg_wr  output  1  register-file write strobe.
- reg_dst  output  2  write register select: 00 rt, 01 rd, 10 $31.
- wb_sel  output  2  write-back data: 00 ALU, 01 memory, 10 PC (link).
- alu_src  output  1  0 = rt, 1 = extended immediate.
- ext_op  output  2  00 zero-extend, 01 sign-extend, 10 shift left 16.
- alu_op  output  2  00 add, 01 sub, 10 or.
- mem_wr  output  1  data-memory write strobe.
- illegal  output  1  one-cycle pulse on an unsupported opcode or funct.
- state  output  4  current state, for debug.

Behaviour:
- Reset:
  - reset low forces state = FETCH and ir = 0 immediately.
  - All strobes (pc_wr, reg_wr, mem_wr, illegal) are combinationally gated to 0 while reset is low.
  - All select outputs are 0 during reset.
  - Reset asserted mid-instruction abandons it; no partial write occurs after reset assertion.
- Outputs are a pure function of state and ir (Moore). Next state is registered.
- FETCH: pc_wr = 1, all selects 0 (PC+4). ir <= code on the leaving edge. Next state is DECODE.
- DECODE: no strobes. Next state is chosen by opcode/funct as follows.
  - R-type addu/subu, ori, lui: EXEC.
  - lw, sw: MEM_ADDR.
  - beq: BRANCH.
  - j, jal, jr: JUMP.
  - Anything else: illegal = 1, then FETCH.
- EXEC: ALU controls for the instruction.
  - R-type: alu_src 0, alu_op add or sub.
  - ori: alu_src 1, ext 00, alu_op or.
  - lui: alu_src 1, ext 10, alu_op or.
  - Next state is ALU_WB.
- ALU_WB: reg_wr = 1, wb_sel = 00, reg_dst = 01 for R-type and 00 otherwise. Next state is FETCH.
- MEM_ADDR: alu_src 1, ext 01, alu_op add. Next state is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: ALU controls held. Next state is MEM_WB.
- MEM_WB: reg_wr = 1, wb_sel = 01, reg_dst = 00. Next state is FETCH.
- MEM_WR: mem_wr = 1, ALU controls held. Next state is FETCH.
- BRANCH: alu_op sub, alu_src 0, npc_sel = 1, pc_wr = zero. Next state is FETCH.
  - The fetch unit adds the offset to the already-incremented PC.
- JUMP: pc_wr = 1.
  - j: jsome = 1.
  - jal: jsome = 1, plus reg_wr = 1, reg_dst = 10, wb_sel = 10; the link is the current PC, already PC+4.
  - jr: jr = 1.
  - Next state is FETCH.
- Latency (cycles, FETCH through the last state): R-type/ori/lui 4, lw 5, sw 4, beq 3, j/jal/jr 3.
- Only one PC write per state. The selects jsome, jr and npc_sel are mutually exclusive in every state.
- rt = $0 or rd = $0 writes are still issued; the register file discards them.

Optional Feature:
- Macro: MCTRL_PERF_EN.
- With the macro defined:
  - Adds output cyc_cnt[CNT_W-1:0], counting every clock since reset.
  - Adds output ret_cnt[CNT_W-1:0], incrementing when leaving a terminal state to FETCH, excluding illegal.
  - Both counters wrap at 2^CNT_W and are cleared by reset.
- Without the macro: neither port nor its logic exists; the rest of the behaviour is identical.

Decomposition:
- Package mips_defs_pkg holds:
  - opcode constants: OP_RTYPE 000000, OP_ORI 001101, OP_LUI 001111, OP_LW 100011, OP_SW 101011, OP_BEQ 000100, OP_J 000010, OP_JAL 000011;
  - funct constants: F_ADDU 100001, F_SUBU 100011, F_JR 001000;
  - state encodings (FETCH = 0 … JUMP = 9);
  - alu_op, ext_op, reg_dst and wb_sel encodings.
- One natural sub-module, insn_class_dec: a combinational ir → one-hot instruction class, including illegal. The FSM and output decode stay in the top module.

Test Plan:
- Release reset with code = 0x00221821 (addu $3,$1,$2):
  - states go FETCH, DECODE, EXEC, ALU_WB, FETCH;
  - pc_wr only in cycle 1;
  - reg_wr = 1 with reg_dst = 01 in cycle 4;
  - ir = 0x00221821.
- code = 0x8C080004 (lw):
  - 5 cycles;
  - reg_wr with wb_sel = 01 in MEM_WB only;
  - mem_wr never asserted.
- code = 0x1000FFFF (beq):
  - with zero = 1: BRANCH has pc_wr = 1 and npc_sel = 1;
  - with zero = 0: BRANCH has pc_wr = 0;
  - both cases take 3 cycles.
- code = 0x0C000010 (jal):
  - JUMP has pc_wr, jsome, reg_wr, reg_dst = 10, wb_sel = 10.
- code = 0x03E00008 (jr): JUMP has jr = 1, jsome = 0.
- code = 0xFC000000: illegal pulses for 1 cycle in DECODE, then FETCH.
- Pull reset low during MEM_WR: mem_wr drops at once, and state = FETCH before the next edge.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// Shared MIPS encodings for the multi-cycle controller: opcodes, functs, FSM states,
// datapath select encodings and the one-hot instruction class used by the decoder.
package mips_defs_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] F_ADDU   = 6'b100001;
    localparam logic [5:0] F_SUBU   = 6'b100011;
    localparam logic [5:0] F_JR     = 6'b001000;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC     = 4'd2,
        ALU_WB   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WB   = 4'd6,
        MEM_WR   = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9
    } state_t;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_OR   = 2'b10;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    localparam logic [1:0] RD_RT    = 2'b00;
    localparam logic [1:0] RD_RD    = 2'b01;
    localparam logic [1:0] RD_RA    = 2'b10;

    localparam logic [1:0] WB_ALU   = 2'b00;
    localparam logic [1:0] WB_MEM   = 2'b01;
    localparam logic [1:0] WB_PC    = 2'b10;

    typedef struct packed {
        logic addu;
        logic subu;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
        logic jr;
        logic ill;
    } insn_cls_t;

endpackage

// File: rtl/insn_class_dec.sv
// Instruction classifier: opcode/funct to one-hot class, with unsupported encodings as ill.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module insn_class_dec
    import mips_defs_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output insn_cls_t  cls
);

    always_comb begin
        cls = '0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    F_ADDU:  cls.addu = 1'b1;
                    F_SUBU:  cls.subu = 1'b1;
                    F_JR:    cls.jr   = 1'b1;
                    default: cls.ill  = 1'b1;
                endcase
            end
            OP_ORI:  cls.ori = 1'b1;
            OP_LUI:  cls.lui = 1'b1;
            OP_LW:   cls.lw  = 1'b1;
            OP_SW:   cls.sw  = 1'b1;
            OP_BEQ:  cls.beq = 1'b1;
            OP_J:    cls.j   = 1'b1;
            OP_JAL:  cls.jal = 1'b1;
            default: cls.ill = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: latches the fetched word into ir and sequences the datapath strobes.
// Latency: 3 to 5 cycles per instruction; outputs are a Moore decode of state and ir.
// Backpressure: none; MCTRL_PERF_EN adds cycle and retired-instruction counters.
module multicycle_ctrl
    import mips_defs_pkg::*;
`ifdef MCTRL_PERF_EN
#(
    parameter int CNT_W = 32
)
`endif
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] code,
    input  logic        zero,
    output logic [31:0] ir,
    output logic        pc_wr,
    output logic        npc_sel,
    output logic        jsome,
    output logic        jr,
    output logic        reg_wr,
    output logic [1:0]  reg_dst,
    output logic [1:0]  wb_sel,
    output logic        alu_src,
    output logic [1:0]  ext_op,
    output logic [1:0]  alu_op,
    output logic        mem_wr,
    output logic        illegal,
    output logic [3:0]  state
`ifdef MCTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt
`endif
);

    state_t    st;
    insn_cls_t cls;
    logic      pc_wr_c, reg_wr_c, mem_wr_c, ill_c;

    insn_class_dec u_dec (
        .op    (ir[31:26]),
        .funct (ir[5:0]),
        .cls   (cls)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st <= FETCH;
            ir <= '0;
        end else begin
            case (st)
                FETCH: begin
                    ir <= code;
                    st <= DECODE;
                end
                DECODE: begin
                    if (cls.ill)
                        st <= FETCH;
                    else if (cls.addu | cls.subu | cls.ori | cls.lui)
                        st <= EXEC;
                    else if (cls.lw | cls.sw)
                        st <= MEM_ADDR;
                    else if (cls.beq)
                        st <= BRANCH;
                    else
                        st <= JUMP;
                end
                EXEC:     st <= ALU_WB;
                MEM_ADDR: st <= cls.lw ? MEM_RD : MEM_WR;
                MEM_RD:   st <= MEM_WB;
                default:  st <= FETCH;
            endcase
        end
    end

    // ALU controls stay asserted through the write-back states so the result is stable while written.
    always_comb begin
        pc_wr_c  = 1'b0;
        reg_wr_c = 1'b0;
        mem_wr_c = 1'b0;
        ill_c    = 1'b0;
        npc_sel  = 1'b0;
        jsome    = 1'b0;
        jr       = 1'b0;
        reg_dst  = RD_RT;
        wb_sel   = WB_ALU;
        alu_src  = 1'b0;
        ext_op   = EXT_ZERO;
        alu_op   = ALU_ADD;
        case (st)
            FETCH:  pc_wr_c = 1'b1;
            DECODE: ill_c   = cls.ill;
            EXEC, ALU_WB: begin
                alu_src = ~(cls.addu | cls.subu);
                ext_op  = cls.lui ? EXT_LUI : EXT_ZERO;
                alu_op  = cls.subu ? ALU_SUB : ((cls.ori | cls.lui) ? ALU_OR : ALU_ADD);
                if (st == ALU_WB) begin
                    reg_wr_c = 1'b1;
                    reg_dst  = (cls.addu | cls.subu) ? RD_RD : RD_RT;
                end
            end
            MEM_ADDR, MEM_RD, MEM_WB, MEM_WR: begin
                alu_src  = 1'b1;
                ext_op   = EXT_SIGN;
                alu_op   = ALU_ADD;
                mem_wr_c = (st == MEM_WR);
                if (st == MEM_WB) begin
                    reg_wr_c = 1'b1;
                    wb_sel   = WB_MEM;
                end
            end
            BRANCH: begin
                alu_op  = ALU_SUB;
                npc_sel = 1'b1;
                pc_wr_c = zero;
            end
            JUMP: begin
                pc_wr_c = 1'b1;
                jsome   = cls.j | cls.jal;
                jr      = cls.jr;
                if (cls.jal) begin
                    reg_wr_c = 1'b1;
                    reg_dst  = RD_RA;
                    wb_sel   = WB_PC;
                end
            end
            default: ;
        endcase
    end

    // Strobes are masked by reset directly so an abandoned instruction cannot write anything.
    assign pc_wr   = pc_wr_c  & reset;
    assign reg_wr  = reg_wr_c & reset;
    assign mem_wr  = mem_wr_c & reset;
    assign illegal = ill_c    & reset;
    assign state   = st;

`ifdef MCTRL_PERF_EN
    logic retire;
    assign retire = (st == ALU_WB) || (st == MEM_WB) || (st == MEM_WR) ||
                    (st == BRANCH) || (st == JUMP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
            if (retire)
                ret_cnt <= ret_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
